mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one byte-enabled, combinational-read, synchronous-write memory.
- Port 0 is instruction fetch; port 1 is load/store.
- Per-cycle round-robin arbitration with a bounded lock for atomic read-modify-write sequences.
- Registered responses.
- Sits between the CPU front/back ends and the memory's addr/wdata/wenable/rdata port.

Parameters:
- LOCK_TIMEOUT, 16: maximum consecutive accepted cycles a locked port may hold the grant before forced release; valid range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- p0_valid  in  1  port 0 request valid
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_wenable  in  4  port 0 byte write enables; 0 = read
- p0_lock  in  1  port 0 requests to keep the grant after this access
- p0_ready  out  1  port 0 request accepted this cycle
- p0_rsp_valid  out  1  port 0 response valid
- p0_rsp_rdata  out  32  port 0 response data
- p1_*  same set for port 1
- mem_addr  out  32  to memory addr
- mem_wdata  out  32  to memory wdata
- mem_wenable  out  4  to memory wenable
- mem_rdata  in  32  from memory rdata, combinational, pre-write contents

Behaviour:
- Handshake and grant
  - A request is accepted on a cycle where valid && ready.
  - At most one ready is high per cycle.
  - ready is combinational from the valids and registered state.
  - The granted port's addr/wdata/wenable drive the mem_* outputs combinationally.
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_wenable = 0.
  - mem_wenable never goes nonzero without a grant.
- Arbitration (lock not held)
  - Exactly one valid: that port is granted.
  - Both valid: the port not recorded in last_grant is granted.
  - last_grant updates to the accepted port on each accept.
  - No valid: no grant; last_grant unchanged.
- Lock FSM
  - States: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED -> LOCKEDn: port n is accepted with pn_lock = 1. lock_cnt loads 1.
  - In LOCKEDn, only port n can be granted, whatever the other port's valid and last_grant.
  - In LOCKEDn, each accept of port n with pn_lock = 1 increments lock_cnt.
  - LOCKEDn -> UNLOCKED on any of:
    - an accept with pn_lock = 0;
    - pn_valid = 0 for one cycle (the cycle itself grants nothing);
    - an accept that brings lock_cnt to LOCK_TIMEOUT.
  - Timeout release is taken regardless of pn_lock.
  - On timeout release, last_grant = n, so a waiting other port wins next.
  - lock_cnt is 8 bits and saturates; it is cleared in UNLOCKED.
- Response
  - The cycle after an accept on port n: pn_rsp_valid = 1 for exactly one cycle.
  - pn_rsp_rdata = mem_rdata sampled at the accept edge.
  - For writes, the response returns pre-write contents.
  - pn_rsp_rdata holds its value until the next port-n response.
  - Back-to-back accepts produce back-to-back responses; latency is fixed at 1 and there is no backpressure on responses.
- Reset (synchronous, wins over everything)
  - State = UNLOCKED, last_grant = 1 (port 0 wins the first contention), lock_cnt = 0.
  - Both rsp_valid = 0, both rsp_rdata = 0.
  - Reset mid-lock drops the lock.
  - A request presented while rst = 1 is not accepted: ready = 0, mem_wenable = 0.
- Requesters must hold valid and payload stable until ready; the arbiter does not check this.

Test Plan:
- Reset, then p0 read of addr 0x10 alone (memory word 0xDEADBEEF):
  - p0_ready = 1 that cycle, mem_addr = 0x10, mem_wenable = 0.
  - Next cycle p0_rsp_valid = 1, p0_rsp_rdata = 0xDEADBEEF; p1_rsp_valid = 0.
- Both valid for 4 cycles after reset, no locks:
  - Grants go p0, p1, p0, p1.
  - Responses appear on the matching port one cycle after each accept.
- p1 write addr 0x20, wdata 0x11223344, wenable 4'b0011, old word 0xAABBCCDD:
  - p1_rsp_rdata = 0xAABBCCDD.
  - A subsequent p0 read of 0x20 returns 0xAABB3344.
- p1 lock sequence: read 0x30 with lock = 1, then write 0x30 with lock = 0, p0 valid throughout:
  - Both p1 accesses are granted consecutively; p0_ready = 0 for both cycles.
  - p0 is granted on the third cycle.
- LOCK_TIMEOUT = 3, p0 holds lock = 1 with p1 valid:
  - p0 gets exactly 3 consecutive grants.
  - p1 is granted on the 4th cycle; the FSM is back in UNLOCKED.
- Assert rst in the cycle after a locked p0 accept:
  - rst cycle: no ready, mem_wenable = 0, rsp_valid = 0.
  - After rst falls, with both valid, p0 wins (last_grant = 1).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a combinational-read, synchronous-write
// memory, with a bounded grant lock for atomic read-modify-write sequences.
module mem_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wenable,
  input  logic        p0_lock,
  output logic        p0_ready,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  input  logic        p1_valid,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wenable,
  input  logic        p1_lock,
  output logic        p1_ready,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wenable,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

  localparam logic [7:0] TIMEOUT = 8'(LOCK_TIMEOUT);

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic        gnt0, gnt1, acc, acc_lock;
  logic [7:0]  cnt_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cnt_inc = sat_inc(lock_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      last_grant <= 1'b1;
      lock_cnt   <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    lock_cnt_nxt   = lock_cnt;
    // Nothing is granted during reset, so no write can slip through.
    if (!rst) begin
      case (state)
        LOCKED0: gnt0 = p0_valid;
        LOCKED1: gnt1 = p1_valid;
        default: begin
          if (p0_valid && p1_valid) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
          end else begin
            gnt0 = p0_valid;
            gnt1 = p1_valid;
          end
        end
      endcase
    end
    acc      = gnt0 | gnt1;
    acc_lock = gnt0 ? p0_lock : p1_lock;
    if (acc) last_grant_nxt = gnt1;
    case (state)
      UNLOCKED: begin
        lock_cnt_nxt = 8'd0;
        // A timeout of 1 means the locking access itself exhausts the budget.
        if (acc && acc_lock && (TIMEOUT > 8'd1)) begin
          state_nxt    = gnt1 ? LOCKED1 : LOCKED0;
          lock_cnt_nxt = 8'd1;
        end
      end
      LOCKED0, LOCKED1: begin
        if (!acc || !acc_lock || (cnt_inc >= TIMEOUT)) begin
          state_nxt    = UNLOCKED;
          lock_cnt_nxt = 8'd0;
        end else begin
          lock_cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt    = UNLOCKED;
        lock_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign p0_ready    = gnt0;
  assign p1_ready    = gnt1;
  assign mem_addr    = gnt0 ? p0_addr    : (gnt1 ? p1_addr    : 32'd0);
  assign mem_wdata   = gnt0 ? p0_wdata   : (gnt1 ? p1_wdata   : 32'd0);
  assign mem_wenable = gnt0 ? p0_wenable : (gnt1 ? p1_wenable : 4'd0);

  // Response stage: capture pre-write read data at the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= 32'd0;
      p1_rsp_rdata <= 32'd0;
    end else begin
      p0_rsp_valid <= gnt0;
      p1_rsp_valid <= gnt1;
      if (gnt0) p0_rsp_rdata <= mem_rdata;
      if (gnt1) p1_rsp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level reference
// model with its own shadow memory.
module tb_mem_arbiter;

  localparam int LT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_lock, p0_ready, p0_rsp_valid;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic [3:0]  p0_wenable;
  logic        p1_valid, p1_lock, p1_ready, p1_rsp_valid;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic [3:0]  p1_wenable;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wenable;

  mem_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wenable(p0_wenable), .p0_lock(p0_lock), .p0_ready(p0_ready),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wenable(p1_wenable), .p1_lock(p1_lock), .p1_ready(p1_ready),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'hDEADBEEF;
      8:       return 32'hAABBCCDD;
      12:      return 32'h0BADF00D;
      default: return 32'h01010101 * i;
    endcase
  endfunction

  // Memory under the arbiter: combinational read, byte-enabled write.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wenable[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] mmem [16];
  int          m_hold = -1;
  int          m_run  = 0;
  int          m_last = 1;
  int          m_g    = -1;
  bit          m_init = 0;
  bit          m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;

  task automatic cycle(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] w0, input logic l0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [3:0] w1, input logic l1, input logic r);
    logic [31:0] ea, ed, old;
    logic [3:0]  ew;
    logic        el;
    int          g;
    p0_valid = v0; p0_addr = a0; p0_wdata = d0; p0_wenable = w0; p0_lock = l0;
    p1_valid = v1; p1_addr = a1; p1_wdata = d1; p1_wenable = w1; p1_lock = l1;
    rst = r;
    #4;
    if (r) g = -1;
    else if (m_hold >= 0) g = ((m_hold == 0) ? v0 : v1) ? m_hold : -1;
    else if (v0 && v1) g = (m_last == 1) ? 0 : 1;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    m_g = g;
    ea = (g == 0) ? a0 : (g == 1) ? a1 : 32'd0;
    ed = (g == 0) ? d0 : (g == 1) ? d1 : 32'd0;
    ew = (g == 0) ? w0 : (g == 1) ? w1 : 4'd0;
    el = (g == 0) ? l0 : l1;
    check("p0_ready", {31'd0, p0_ready}, {31'd0, g == 0});
    check("p1_ready", {31'd0, p1_ready}, {31'd0, g == 1});
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("mem_wenable", {28'd0, mem_wenable}, {28'd0, ew});
    if (m_init) begin
      check("p0_rsp_valid", {31'd0, p0_rsp_valid}, {31'd0, m_rv0});
      check("p1_rsp_valid", {31'd0, p1_rsp_valid}, {31'd0, m_rv1});
      check("p0_rsp_rdata", p0_rsp_rdata, m_rd0);
      check("p1_rsp_rdata", p1_rsp_rdata, m_rd1);
    end
    if (r) begin
      m_hold = -1; m_run = 0; m_last = 1;
      m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0;
      for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
      m_init = 1;
    end else begin
      m_rv0 = (g == 0);
      m_rv1 = (g == 1);
      if (g >= 0) begin
        old = mmem[ea[5:2]];
        if (g == 0) m_rd0 = old; else m_rd1 = old;
        for (int b = 0; b < 4; b++)
          if (ew[b]) mmem[ea[5:2]][8*b +: 8] = ed[8*b +: 8];
        m_last = g;
        if (m_hold < 0) begin
          if (el) begin
            m_run  = 1;
            m_hold = (m_run >= LT) ? -1 : g;
            if (m_hold < 0) m_run = 0;
          end
        end else begin
          m_run++;
          if (!el || m_run >= LT) begin m_hold = -1; m_run = 0; end
        end
      end else if (m_hold >= 0) begin
        m_hold = -1; m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic        hv0, hl0, hv1, hl1;
  logic [31:0] ha0, hd0, ha1, hd1;
  logic [3:0]  hw0, hw1;
  int          p0_grants;

  initial begin
    rst = 1'b1;
    p0_valid = 0; p0_addr = 0; p0_wdata = 0; p0_wenable = 0; p0_lock = 0;
    p1_valid = 0; p1_addr = 0; p1_wdata = 0; p1_wenable = 0; p1_lock = 0;
    @(posedge clk); #1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Lone p0 read of 0x10
    cycle(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_read_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    check("tp_read_p1v", {31'd0, p1_rsp_valid}, 32'd0);

    // Contention alternates starting with p0 after reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    p0_grants = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h4 * i, 0, 0, 0, 1, 32'h40 + 32'h4 * i, 0, 0, 0, 0);
      if (m_g == 0) p0_grants++;
      check("tp_rr_order", {31'd0, p0_rsp_valid}, {31'd0, (i % 2) == 0});
    end
    check("tp_rr_p0_count", p0_grants, 2);

    // Byte-masked write returns old word; later read sees the merge
    cycle(0, 0, 0, 0, 0, 1, 32'h20, 32'h11223344, 4'b0011, 0, 0);
    check("tp_wr_old", p1_rsp_rdata, 32'hAABBCCDD);
    cycle(1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_wr_merge", p0_rsp_rdata, 32'hAABB3344);

    // p1 locked read-modify-write while p0 waits
    cycle(1, 32'h8, 0, 0, 0, 1, 32'h30, 0, 0, 1, 0);
    cycle(1, 32'h8, 0, 0, 0, 1, 32'h30, 32'hCAFEBABE, 4'hF, 0, 0);
    check("tp_lock_p1_second", {31'd0, p1_rsp_valid}, 32'd1);
    cycle(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_lock_p0_third", {31'd0, p0_rsp_valid}, 32'd1);

    // Lock timeout: p0 keeps lock, p1 waits
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'h0, 0, 0, 1, 1, 32'h4, 0, 0, 0, 0);
    check("tp_timeout_p1", {31'd0, p1_rsp_valid}, 32'd1);

    // Reset in the middle of a lock
    cycle(0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 0);
    cycle(1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h0, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h4, 32'h12345678, 4'hF, 0, 1);
    check("tp_rst_rspv0", {31'd0, p0_rsp_valid}, 32'd0);
    cycle(1, 32'h0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 0);
    check("tp_rst_p0_wins", {31'd0, p0_rsp_valid}, 32'd1);

    // Randomized traffic from two well-behaved requesters
    hv0 = 0; hv1 = 0; hl0 = 0; hl1 = 0;
    ha0 = 0; ha1 = 0; hd0 = 0; hd1 = 0; hw0 = 0; hw1 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!hv0 && $urandom_range(0, 9) < 6) begin
        hv0 = 1; ha0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; hd0 = $urandom;
        hw0 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
        hl0 = ($urandom_range(0, 9) < 3);
      end
      if (!hv1 && $urandom_range(0, 9) < 6) begin
        hv1 = 1; ha1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; hd1 = $urandom;
        hw1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
        hl1 = ($urandom_range(0, 9) < 4);
      end
      cycle(hv0, ha0, hd0, hw0, hl0, hv1, ha1, hd1, hw1, hl1,
            ($urandom_range(0, 99) == 0));
      if (m_g == 0) hv0 = 0;
      if (m_g == 1) hv1 = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
